// File: rtl/number_slot_scheduler_if.sv
// Bundle between the number-slot scheduler, the display block and the score unit.
// The master side is the scheduler; the slave side is the game/display/score environment.
interface number_slot_scheduler_if #(
   parameter int NUMBERS = 3
);
   logic                    startOfFrame;
   logic                    enable;
   logic [NUMBERS-1:0]      singleHit;
   logic                    scoreReady;
   logic [NUMBERS-1:0][3:0] numbersToShow;
   logic [NUMBERS-1:0]      showNum;
   logic                    scoreValid;
   logic [3:0]              scoreValue;
   logic [3:0]              scoreSlot;
   logic                    allClear;

   modport master (
      input  startOfFrame, enable, singleHit, scoreReady,
      output numbersToShow, showNum, scoreValid, scoreValue, scoreSlot, allClear
   );

   modport slave (
      output startOfFrame, enable, singleHit, scoreReady,
      input  numbersToShow, showNum, scoreValid, scoreValue, scoreSlot, allClear
   );
endinterface

// File: rtl/number_slot_scheduler.sv
// Per-slot tile state (ACTIVE/PENDING/COOLDOWN), round-robin score serialiser and LFSR digit source.
// Optional all-slots-cleared fast respawn is enabled by defining NUM_SCHED_ALLCLEAR_EN.
module number_slot_scheduler #(
   parameter int         NUMBERS        = 3,
   parameter int         TIMEOUT_FRAMES = 450,
   parameter int         MAX_VALUE      = 9,
   parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
   input  logic                          clk,
   input  logic                          resetN,
   number_slot_scheduler_if.master       bus
);

   localparam int         TW  = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [4:0] MV1 = 5'(MAX_VALUE + 1);

   typedef enum logic [1:0] {ACTIVE, PENDING, COOLDOWN} slot_state_t;

   logic [7:0]        lfsr_reg;
   logic [4:0]        raw_digit;
   logic [3:0]        new_digit;
   logic              score_valid_reg;
   logic [3:0]        score_slot_reg;
   logic [3:0]        score_value_reg;
   logic [3:0]        rr_reg;
   logic              handshake;
   logic              frame_tick;
   logic              clear_event;
   logic              grant;
   logic [3:0]        start_idx;
   logic [3:0]        grant_idx;
   logic [3:0]        grant_digit;
   logic [3:0]        cand;
   logic [NUMBERS-1:0] pending_mask;
   logic [15:0]       pend16;
   logic [15:0][3:0]  digit16;

`ifdef NUM_SCHED_ALLCLEAR_EN
   logic [NUMBERS-1:0] cool_mask;
   logic               clear_done_reg;
   logic               allclear_reg;
`endif

   function automatic logic [3:0] wrap_inc(input logic [3:0] s);
      return (s == 4'(NUMBERS - 1)) ? 4'd0 : s + 4'd1;
   endfunction

   // Fold the 0..15 nibble into 0..MAX_VALUE with a single subtraction
   assign raw_digit  = {1'b0, lfsr_reg[3:0]};
   assign new_digit  = (raw_digit >= MV1) ? 4'(raw_digit - MV1) : lfsr_reg[3:0];
   assign frame_tick = bus.startOfFrame & bus.enable;
   assign handshake  = score_valid_reg & bus.scoreReady;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lfsr_reg <= LFSR_SEED;
      end else begin
         lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      end
   end

   generate
      for (genvar gi = 0; gi < NUMBERS; gi++) begin : slot_g
         localparam logic [3:0] RST_DIGIT = 4'(gi % (MAX_VALUE + 1));

         slot_state_t   state_reg;
         logic [TW-1:0] timer_reg;
         logic [3:0]    digit_reg;
         logic          show_reg;
         logic          hs_here;

         assign hs_here = handshake && (score_slot_reg == 4'(gi));

         always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
               state_reg <= ACTIVE;
               timer_reg <= '0;
               digit_reg <= RST_DIGIT;
               show_reg  <= 1'b1;
            end else begin
               case (state_reg)
                  ACTIVE: begin
                     if (bus.singleHit[gi] && bus.enable) begin
                        state_reg <= PENDING;
                        show_reg  <= 1'b0;
                     end
                  end
                  PENDING: begin
                     if (hs_here) begin
                        state_reg <= COOLDOWN;
                        timer_reg <= TW'(TIMEOUT_FRAMES);
                     end
                  end
                  COOLDOWN: begin
                     if (clear_event) begin
                        timer_reg <= TW'(1);
                     end else if (frame_tick) begin
                        if (timer_reg == TW'(1)) begin
                           state_reg <= ACTIVE;
                           show_reg  <= 1'b1;
                           digit_reg <= new_digit;
                           timer_reg <= '0;
                        end else if (timer_reg != '0) begin
                           timer_reg <= timer_reg - TW'(1);
                        end
                     end
                  end
                  default: state_reg <= ACTIVE;
               endcase
            end
         end

         assign bus.numbersToShow[gi] = digit_reg;
         assign bus.showNum[gi]       = show_reg;
         // The slot being handshaken this cycle must not be granted again
         assign pending_mask[gi]      = (state_reg == PENDING) && !hs_here;
`ifdef NUM_SCHED_ALLCLEAR_EN
         assign cool_mask[gi]         = (state_reg == COOLDOWN);
`endif
      end
   endgenerate

   // Scan downward so the last hit wins, i.e. the first pending slot at/after start_idx
   always_comb begin
      pend16                   = '0;
      pend16[NUMBERS-1:0]      = pending_mask;
      digit16                  = '0;
      digit16[NUMBERS-1:0]     = bus.numbersToShow;
      start_idx                = handshake ? wrap_inc(score_slot_reg) : rr_reg;
      grant                    = 1'b0;
      grant_idx                = '0;
      grant_digit              = '0;
      cand                     = '0;
      for (int k = NUMBERS - 1; k >= 0; k--) begin
         cand = 4'((int'(start_idx) + k) % NUMBERS);
         if (pend16[cand]) begin
            grant       = 1'b1;
            grant_idx   = cand;
            grant_digit = digit16[cand];
         end
      end
      if (score_valid_reg && !handshake) begin
         grant = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         score_valid_reg <= 1'b0;
         score_slot_reg  <= '0;
         score_value_reg <= '0;
         rr_reg          <= '0;
      end else begin
         if (grant) begin
            score_valid_reg <= 1'b1;
            score_slot_reg  <= grant_idx;
            score_value_reg <= grant_digit;
         end else if (handshake) begin
            score_valid_reg <= 1'b0;
         end
         if (handshake) begin
            rr_reg <= wrap_inc(score_slot_reg);
         end
      end
   end

   assign bus.scoreValid = score_valid_reg;
   assign bus.scoreSlot  = score_slot_reg;
   assign bus.scoreValue = score_value_reg;

`ifdef NUM_SCHED_ALLCLEAR_EN
   // clear_done_reg remembers the current all-cooldown episode so it pulses only once
   assign clear_event = (&cool_mask) && !clear_done_reg;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         clear_done_reg <= 1'b0;
         allclear_reg   <= 1'b0;
      end else begin
         clear_done_reg <= &cool_mask;
         allclear_reg   <= clear_event;
      end
   end

   assign bus.allClear = allclear_reg;
`else
   assign clear_event  = 1'b0;
   assign bus.allClear = 1'b0;
`endif

endmodule

// File: tb/tb_number_slot_scheduler.sv
// Directed bench for number_slot_scheduler (NUMBERS=3, TIMEOUT_FRAMES=450, MAX_VALUE=9).
// Expectations follow NUM_SCHED_ALLCLEAR_EN when it is defined for the build.
module tb_number_slot_scheduler;

   logic clk;
   logic resetN;
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   logic [3:0] exp_dig [3];

`ifdef NUM_SCHED_ALLCLEAR_EN
   localparam int   PRE     = 0;
   localparam logic EXP_CLR = 1'b1;
`else
   localparam int   PRE     = 449;
   localparam logic EXP_CLR = 1'b0;
`endif

   number_slot_scheduler_if #(.NUMBERS(3)) bus ();

   number_slot_scheduler #(
      .NUMBERS(3), .TIMEOUT_FRAMES(450), .MAX_VALUE(9), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_cnt <= resetN ? edge_cnt + 1 : 0;

   always @(posedge clk) begin
      if (resetN && bus.scoreValid && bus.scoreReady)
         $display("score handshake: slot=%0d value=%0d", bus.scoreSlot, bus.scoreValue);
   end

   function automatic logic [3:0] model_digit(input int n);
      logic [7:0] l = 8'hA5;
      logic [3:0] d;
      for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      d = l[3:0];
      if (d > 4'd9) d = d - 4'd10;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      tick();
   endtask

   task automatic respawn(input int pre, input logic [2:0] hidden);
      logic [2:0] vis;
      logic [3:0] d;
      vis = ~hidden;
      repeat (pre) frame();
      if (pre > 0) chk("still_hidden", bus.showNum, vis);
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      chk("respawn_show", bus.showNum, 3'b111);
      d = model_digit(edge_cnt - 1);
      for (int i = 0; i < 3; i++) begin
         if (hidden[i]) begin
            exp_dig[i] = d;
            chk("respawn_digit", bus.numbersToShow[i], d);
         end
      end
   endtask

   initial begin
      resetN           = 1'b0;
      bus.startOfFrame = 1'b0;
      bus.enable       = 1'b1;
      bus.singleHit    = 3'b000;
      bus.scoreReady   = 1'b0;
      #12;
      chk("rst_numbers", bus.numbersToShow, 12'h210);
      chk("rst_show", bus.showNum, 3'b111);
      chk("rst_valid", bus.scoreValid, 1'b0);
      chk("rst_value", bus.scoreValue, 4'd0);
      chk("rst_slot", bus.scoreSlot, 4'd0);
      chk("rst_allclear", bus.allClear, 1'b0);
      #10 resetN = 1'b1;
      tick();

      // All three hit while the score unit stalls
      bus.singleHit = 3'b111;
      tick();
      bus.singleHit = 3'b000;
      chk("hit_all_show", bus.showNum, 3'b000);
      chk("hit_all_valid0", bus.scoreValid, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_valid", bus.scoreValid, 1'b1);
         chk("stall_slot", bus.scoreSlot, 4'd0);
         chk("stall_value", bus.scoreValue, 4'd0);
      end
      bus.scoreReady = 1'b1;
      tick();
      chk("b2b_valid1", bus.scoreValid, 1'b1);
      chk("b2b_slot1", bus.scoreSlot, 4'd1);
      chk("b2b_value1", bus.scoreValue, 4'd1);
      tick();
      chk("b2b_valid2", bus.scoreValid, 1'b1);
      chk("b2b_slot2", bus.scoreSlot, 4'd2);
      chk("b2b_value2", bus.scoreValue, 4'd2);
      tick();
      chk("b2b_drop", bus.scoreValid, 1'b0);
      tick();
      chk("allclear_pulse", bus.allClear, EXP_CLR);
      tick();
      chk("allclear_once", bus.allClear, 1'b0);
      respawn(PRE, 3'b111);

      // Single hit on slot 1 leaves the round-robin pointer at 2
      bus.singleHit = 3'b010;
      tick();
      bus.singleHit = 3'b000;
      chk("hit1_show", bus.showNum, 3'b101);
      tick();
      chk("hit1_valid", bus.scoreValid, 1'b1);
      chk("hit1_slot", bus.scoreSlot, 4'd1);
      chk("hit1_value", bus.scoreValue, exp_dig[1]);
      tick();
      chk("hit1_drop", bus.scoreValid, 1'b0);
      bus.singleHit = 3'b101;
      tick();
      bus.singleHit = 3'b000;
      chk("rr_show", bus.showNum, 3'b000);
      tick();
      chk("rr_first_slot", bus.scoreSlot, 4'd2);
      chk("rr_first_value", bus.scoreValue, exp_dig[2]);
      tick();
      chk("rr_second_valid", bus.scoreValid, 1'b1);
      chk("rr_second_slot", bus.scoreSlot, 4'd0);
      chk("rr_second_value", bus.scoreValue, exp_dig[0]);
      tick();
      chk("rr_drop", bus.scoreValid, 1'b0);
      tick();
      chk("allclear_pulse2", bus.allClear, EXP_CLR);
      respawn(PRE, 3'b111);

      // Slot 1 into cooldown, slot 0 pending when the game pauses
      bus.singleHit = 3'b010;
      tick();
      bus.singleHit = 3'b000;
      tick();
      chk("en_slot1", bus.scoreSlot, 4'd1);
      tick();
      chk("en_slot1_drop", bus.scoreValid, 1'b0);
      bus.scoreReady = 1'b0;
      bus.singleHit  = 3'b001;
      tick();
      bus.singleHit  = 3'b000;
      tick();
      chk("en_pend_valid", bus.scoreValid, 1'b1);
      chk("en_pend_slot", bus.scoreSlot, 4'd0);
      bus.enable    = 1'b0;
      bus.singleHit = 3'b100;
      tick();
      bus.singleHit = 3'b000;
      chk("dis_hit_ignored", bus.showNum, 3'b100);
      repeat (20) frame();
      chk("dis_valid_hold", bus.scoreValid, 1'b1);
      chk("dis_value_hold", bus.scoreValue, exp_dig[0]);
      bus.scoreReady = 1'b1;
      tick();
      chk("dis_handshake", bus.scoreValid, 1'b0);
      chk("dis_show", bus.showNum, 3'b100);
      bus.scoreReady = 1'b0;
      bus.enable     = 1'b1;
      respawn(449, 3'b011);
      chk("no_allclear", bus.allClear, 1'b0);

      // Asynchronous reset drops a pending score event immediately
      bus.singleHit = 3'b100;
      tick();
      bus.singleHit = 3'b000;
      tick();
      chk("pre_rst_valid", bus.scoreValid, 1'b1);
      #2 resetN = 1'b0;
      #1;
      chk("mid_rst_valid", bus.scoreValid, 1'b0);
      chk("mid_rst_show", bus.showNum, 3'b111);
      chk("mid_rst_numbers", bus.numbersToShow, 12'h210);
      chk("mid_rst_slot", bus.scoreSlot, 4'd0);
      #4 resetN = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
